stream_frame_deframer: RTL and testbench



---
 rtl/stream_frame_deframer_pkg.sv | 26 ++
 rtl/stream_frame_deframer_if.sv | 15 +
 rtl/stream_frame_deframer_axis_out_reg.sv | 44 ++++
 rtl/stream_frame_deframer.sv | 241 ++++++++++++++++++++++++
 tb/tb_stream_frame_deframer.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/stream_frame_deframer_pkg.sv
// Shared definitions for the stream frame deframer.
// - state_t   : parser state encoding (header / payload / footer / drop)
// - beat_num  : number of stream beats needed to carry a field of a given width
// - cnt_w     : index counter width for a field of n beats (minimum 1 bit)
package stream_frame_deframer_pkg;

    typedef enum logic [1:0] {
        ST_HEADER  = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_FOOTER  = 2'd2,
        ST_DROP    = 2'd3
    } state_t;

    // Defaults for an 8-bit stream with a 16-bit length and a 72-bit timestamp.
    localparam int FRAME_LENGTH_BEAT_NUM_DEFAULT = 2;
    localparam int TIMESTAMP_BEAT_NUM_DEFAULT    = 9;

    function automatic int beat_num(input int field_width, input int data_width);
        return field_width / data_width;
    endfunction

    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/stream_frame_deframer_if.sv
// AXI-Stream style handshake bundle used for both the input and output side
// of the deframer.
// - master : drives tdata/tvalid/tlast, samples tready
// - slave  : samples tdata/tvalid/tlast, drives tready
interface stream_frame_deframer_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/stream_frame_deframer_axis_out_reg.sv
// One-entry AXI-Stream output register.
// Ports:
//   clk, rstn            : clock, asynchronous active-low reset
//   in_tdata/in_tlast    : beat to be registered
//   in_tvalid/in_tready  : upstream handshake; in_tready = register empty or draining
//   m                    : registered stream towards the consumer
// The register holds data/last stable while m.tready is low. Reset clears the
// valid flag asynchronously so a partially delivered beat disappears at once.
module axis_out_reg #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [DATA_WIDTH-1:0] in_tdata,
    input  logic                  in_tvalid,
    input  logic                  in_tlast,
    output logic                  in_tready,
    stream_frame_deframer_if.master m
);
    logic [DATA_WIDTH-1:0] data_q;
    logic                  valid_q;
    logic                  last_q;

    assign in_tready = !valid_q || m.tready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else if (in_tready) begin
            valid_q <= in_tvalid;
            if (in_tvalid) begin
                data_q <= in_tdata;
                last_q <= in_tlast;
            end
        end
    end

    assign m.tdata  = data_q;
    assign m.tvalid = valid_q;
    assign m.tlast  = last_q;

endmodule

// File: rtl/stream_frame_deframer.sv
// Stream frame deframer: strips an optional LSB-first length header and an
// optional LSB-first timestamp footer from each frame, forwards the payload
// with a regenerated tlast, exports the timestamp and reports framing errors.
// Ports:
//   clk, rstn        : clock, asynchronous active-low reset
//   s_axis           : input stream (header + payload + footer)
//   m_axis           : payload stream, registered (1 cycle latency)
//   m_ts/m_ts_valid  : captured footer timestamp, valid pulse on update
//   m_frame_length   : header value of the current/last frame (beat count
//                      of the current frame when there is no header)
//   err_short/err_long/err_length : one-cycle error pulses
//   frames_ok/frames_err          : saturating frame counters
module stream_frame_deframer
    import stream_frame_deframer_pkg::*;
#(
    parameter int DATA_WIDTH                 = 8,
    parameter bit ENABLE_FRAME_LENGTH_HEADER = 1'b1,
    parameter bit ENABLE_TIMESTAMP_FOOTER    = 1'b1,
    parameter int FRAME_LENGTH_WIDTH         = 16,
    parameter int TIMESTAMP_WIDTH            = 72,
    parameter int MAX_FRAME_BEATS            = 1600
) (
    input  logic                          clk,
    input  logic                          rstn,
    stream_frame_deframer_if.slave        s_axis,
    stream_frame_deframer_if.master       m_axis,
    output logic [TIMESTAMP_WIDTH-1:0]    m_ts,
    output logic                          m_ts_valid,
    output logic [FRAME_LENGTH_WIDTH-1:0] m_frame_length,
    output logic                          err_short,
    output logic                          err_long,
    output logic                          err_length,
    output logic [31:0]                   frames_ok,
    output logic [31:0]                   frames_err
);

    localparam int FRAME_LENGTH_BEAT_NUM = beat_num(FRAME_LENGTH_WIDTH, DATA_WIDTH);
    localparam int TIMESTAMP_BEAT_NUM    = beat_num(TIMESTAMP_WIDTH, DATA_WIDTH);
    localparam int MAX_FIELD_BEATS       = (FRAME_LENGTH_BEAT_NUM > TIMESTAMP_BEAT_NUM) ?
                                           FRAME_LENGTH_BEAT_NUM : TIMESTAMP_BEAT_NUM;
    localparam int IDX_W                 = cnt_w(MAX_FIELD_BEATS);
    localparam logic [FRAME_LENGTH_WIDTH:0] MAX_LEN = (FRAME_LENGTH_WIDTH+1)'(MAX_FRAME_BEATS);
    localparam state_t RESET_STATE = ENABLE_FRAME_LENGTH_HEADER ? ST_HEADER : ST_PAYLOAD;

    // Illegal configurations stop elaboration.
    generate
        if (ENABLE_TIMESTAMP_FOOTER && !ENABLE_FRAME_LENGTH_HEADER) begin : g_bad_footer
            $fatal(1, "timestamp footer requires the frame length header");
        end
        if ((FRAME_LENGTH_WIDTH % DATA_WIDTH) != 0) begin : g_bad_len_w
            $fatal(1, "FRAME_LENGTH_WIDTH must be a multiple of DATA_WIDTH");
        end
        if ((TIMESTAMP_WIDTH % DATA_WIDTH) != 0) begin : g_bad_ts_w
            $fatal(1, "TIMESTAMP_WIDTH must be a multiple of DATA_WIDTH");
        end
    endgenerate

    state_t state_q, state_d;

    logic [IDX_W-1:0]              idx_q;       // header / footer beat index
    logic [FRAME_LENGTH_WIDTH-1:0] pay_cnt_q;   // payload beat index
    logic [FRAME_LENGTH_WIDTH-1:0] len_sh_q;    // header shift register
    logic [FRAME_LENGTH_WIDTH-1:0] len_q;       // validated frame length
    logic [TIMESTAMP_WIDTH-1:0]    ts_sh_q;     // footer shift register

    logic s_tready, s_fire;
    logic out_ready, out_valid, out_last;
    logic ev_short, ev_long, ev_length, ev_ok;

    logic [FRAME_LENGTH_WIDTH-1:0] len_shift;
    logic [TIMESTAMP_WIDTH-1:0]    ts_shift;
    logic hdr_last, ftr_last, len_bad, pay_final, pay_early_end;

    // Header/footer beats never wait on the output; payload beats do.
    assign s_tready      = (state_q == ST_PAYLOAD) ? out_ready : 1'b1;
    assign s_axis.tready = s_tready;
    assign s_fire        = s_axis.tvalid && s_tready;

    // New beats enter at the top so the first (least significant) beat ends
    // up at the bottom once the field is complete.
    assign len_shift = (len_sh_q >> DATA_WIDTH) |
                       (FRAME_LENGTH_WIDTH'(s_axis.tdata) << (FRAME_LENGTH_WIDTH - DATA_WIDTH));
    assign ts_shift  = (ts_sh_q >> DATA_WIDTH) |
                       (TIMESTAMP_WIDTH'(s_axis.tdata) << (TIMESTAMP_WIDTH - DATA_WIDTH));

    assign hdr_last  = (idx_q == IDX_W'(FRAME_LENGTH_BEAT_NUM - 1));
    assign ftr_last  = (idx_q == IDX_W'(TIMESTAMP_BEAT_NUM - 1));
    assign len_bad   = (len_shift == '0) || ({1'b0, len_shift} > MAX_LEN);
    assign pay_final = ENABLE_FRAME_LENGTH_HEADER &&
                       (pay_cnt_q == len_q - FRAME_LENGTH_WIDTH'(1));
    // With a footer, any payload tlast is premature (the footer is missing).
    assign pay_early_end = s_axis.tlast && (ENABLE_TIMESTAMP_FOOTER || !pay_final);

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= RESET_STATE;
        else       state_q <= state_d;
    end

    // ---------------- next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_HEADER: begin
                if (s_fire && !s_axis.tlast && hdr_last)
                    state_d = len_bad ? ST_DROP : ST_PAYLOAD;
            end
            ST_PAYLOAD: begin
                if (s_fire && ENABLE_FRAME_LENGTH_HEADER) begin
                    if (pay_early_end)                state_d = ST_HEADER;
                    else if (pay_final) begin
                        if (ENABLE_TIMESTAMP_FOOTER)  state_d = ST_FOOTER;
                        else if (s_axis.tlast)        state_d = ST_HEADER;
                        else                          state_d = ST_DROP;
                    end
                end
            end
            ST_FOOTER: begin
                if (s_fire) begin
                    if (ftr_last)          state_d = s_axis.tlast ? ST_HEADER : ST_DROP;
                    else if (s_axis.tlast) state_d = ST_HEADER;
                end
            end
            default: begin
                if (s_fire && s_axis.tlast) state_d = ST_HEADER;
            end
        endcase
    end

    // ---------------- outputs / events ----------------
    always_comb begin
        out_valid = 1'b0;
        out_last  = 1'b0;
        ev_short  = 1'b0;
        ev_long   = 1'b0;
        ev_length = 1'b0;
        ev_ok     = 1'b0;
        case (state_q)
            ST_HEADER: begin
                if (s_fire && s_axis.tlast)             ev_short  = 1'b1;
                else if (s_fire && hdr_last && len_bad) ev_length = 1'b1;
            end
            ST_PAYLOAD: begin
                out_valid = s_axis.tvalid;
                out_last  = s_axis.tlast || pay_final;
                if (s_fire) begin
                    if (!ENABLE_FRAME_LENGTH_HEADER) ev_ok = s_axis.tlast;
                    else if (pay_early_end)          ev_short = 1'b1;
                    else if (pay_final && !ENABLE_TIMESTAMP_FOOTER) begin
                        ev_ok   = s_axis.tlast;
                        ev_long = !s_axis.tlast;
                    end
                end
            end
            ST_FOOTER: begin
                if (s_fire) begin
                    if (ftr_last) begin
                        ev_ok   = s_axis.tlast;
                        ev_long = !s_axis.tlast;
                    end else if (s_axis.tlast) begin
                        ev_short = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            idx_q          <= '0;
            pay_cnt_q      <= '0;
            len_sh_q       <= '0;
            len_q          <= '0;
            ts_sh_q        <= '0;
            m_ts           <= '0;
            m_ts_valid     <= 1'b0;
            m_frame_length <= '0;
            err_short      <= 1'b0;
            err_long       <= 1'b0;
            err_length     <= 1'b0;
            frames_ok      <= '0;
            frames_err     <= '0;
        end else begin
            m_ts_valid <= 1'b0;
            err_short  <= ev_short;
            err_long   <= ev_long;
            err_length <= ev_length;
            if (ev_ok && (frames_ok != '1))
                frames_ok <= frames_ok + 32'd1;
            // The FSM leaves the frame on every error, so one event per frame.
            if ((ev_short || ev_long || ev_length) && (frames_err != '1))
                frames_err <= frames_err + 32'd1;

            if (s_fire) begin
                case (state_q)
                    ST_HEADER: begin
                        len_sh_q <= len_shift;
                        if (s_axis.tlast || hdr_last) idx_q <= '0;
                        else                          idx_q <= idx_q + IDX_W'(1);
                        if (!s_axis.tlast && hdr_last) begin
                            len_q          <= len_shift;
                            m_frame_length <= len_shift;
                            pay_cnt_q      <= '0;
                        end
                    end
                    ST_PAYLOAD: begin
                        if (ENABLE_FRAME_LENGTH_HEADER) begin
                            pay_cnt_q <= pay_cnt_q + FRAME_LENGTH_WIDTH'(1);
                        end else begin
                            m_frame_length <= pay_cnt_q + FRAME_LENGTH_WIDTH'(1);
                            pay_cnt_q <= s_axis.tlast ? '0 : pay_cnt_q + FRAME_LENGTH_WIDTH'(1);
                        end
                    end
                    ST_FOOTER: begin
                        ts_sh_q <= ts_shift;
                        if (s_axis.tlast || ftr_last) idx_q <= '0;
                        else                          idx_q <= idx_q + IDX_W'(1);
                        if (ftr_last && s_axis.tlast) begin
                            m_ts       <= ts_shift;
                            m_ts_valid <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    axis_out_reg #(.DATA_WIDTH(DATA_WIDTH)) u_out_reg (
        .clk       (clk),
        .rstn      (rstn),
        .in_tdata  (s_axis.tdata),
        .in_tvalid (out_valid),
        .in_tlast  (out_last),
        .in_tready (out_ready),
        .m         (m_axis)
    );

endmodule

// File: tb/tb_stream_frame_deframer.sv
module tb_stream_frame_deframer;

    localparam int DW = 8;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    stream_frame_deframer_if #(.DATA_WIDTH(DW)) s_if();
    stream_frame_deframer_if #(.DATA_WIDTH(DW)) m_if();

    logic [71:0] m_ts;
    logic        m_ts_valid;
    logic [15:0] m_frame_length;
    logic        err_short, err_long, err_length;
    logic [31:0] frames_ok, frames_err;

    stream_frame_deframer dut (
        .clk            (clk),
        .rstn           (rstn),
        .s_axis         (s_if),
        .m_axis         (m_if),
        .m_ts           (m_ts),
        .m_ts_valid     (m_ts_valid),
        .m_frame_length (m_frame_length),
        .err_short      (err_short),
        .err_long       (err_long),
        .err_length     (err_length),
        .frames_ok      (frames_ok),
        .frames_err     (frames_err)
    );

    int n_chk  = 0;
    int n_pass = 0;

    logic [8:0]  exp_q[$];   // {tlast, tdata}
    logic [71:0] ts_q[$];
    logic [2:0]  err_q[$];   // {length, long, short}
    int          exp_ok  = 0;
    int          exp_err = 0;
    bit          ignore_out = 1'b0;
    bit          toggle_en  = 1'b0;

    localparam logic [2:0] E_SHORT  = 3'b001;
    localparam logic [2:0] E_LONG   = 3'b010;
    localparam logic [2:0] E_LENGTH = 3'b100;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [71:0] ts_of(input logic [7:0] fbase);
        logic [71:0] t;
        t = '0;
        for (int i = 0; i < 9; i++) t[8*i +: 8] = fbase + 8'(i);
        return t;
    endfunction

    // ---------------- monitor / scoreboard ----------------
    logic       prev_stall = 1'b0;
    logic [8:0] prev_beat  = '0;

    always @(negedge clk) begin
        if (!ignore_out) begin
            if (prev_stall)
                check("stall_hold", {m_if.tvalid, m_if.tlast, m_if.tdata}, {1'b1, prev_beat});
            if (m_if.tvalid && m_if.tready) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL beat_unexpected: got %0h expected none", {m_if.tlast, m_if.tdata});
                end else begin
                    check("beat", {m_if.tlast, m_if.tdata}, exp_q.pop_front());
                end
            end
        end
        prev_stall = m_if.tvalid && !m_if.tready;
        prev_beat  = {m_if.tlast, m_if.tdata};

        if (m_ts_valid) begin
            if (ts_q.size() == 0) begin
                n_chk++;
                $display("FAIL ts_unexpected: got %0h expected none", m_ts);
            end else begin
                check("m_ts", m_ts, ts_q.pop_front());
            end
        end

        if (err_short || err_long || err_length) begin
            if (err_q.size() == 0) begin
                n_chk++;
                $display("FAIL err_unexpected: got %0b expected none", {err_length, err_long, err_short});
            end else begin
                check("err_kind", {err_length, err_long, err_short}, err_q.pop_front());
            end
        end
    end

    // Output backpressure pattern: flip tready every 3 cycles when enabled.
    always begin
        @(posedge clk);
        #1;
        if (toggle_en) begin
            if (($time / 10) % 3 == 0) m_if.tready = !m_if.tready;
        end
    end

    // ---------------- stimulus ----------------
    task automatic send_beat(input logic [7:0] d, input bit last);
        int t;
        s_if.tdata  = d;
        s_if.tlast  = last;
        s_if.tvalid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!s_if.tready && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 1000) begin
            n_chk++;
            $display("FAIL s_tready_timeout: got 0 expected 1");
        end
        @(posedge clk);
        #1;
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
    endtask

    task automatic send_hdr(input logic [15:0] len);
        send_beat(len[7:0], 1'b0);
        send_beat(len[15:8], 1'b0);
    endtask

    task automatic send_pay(input int n, input logic [7:0] base, input int s_last_idx,
                            input int exp_last_idx, input bit push);
        for (int i = 0; i < n; i++) begin
            if (push) exp_q.push_back({(i == exp_last_idx), base + 8'(i)});
            send_beat(base + 8'(i), (i == s_last_idx));
        end
    endtask

    task automatic send_ftr(input logic [7:0] fbase, input bit last);
        for (int i = 0; i < 9; i++) send_beat(fbase + 8'(i), last && (i == 8));
    endtask

    task automatic good_frame(input int len, input logic [7:0] pbase, input logic [7:0] fbase);
        send_hdr(16'(len));
        send_pay(len, pbase, -1, len - 1, 1'b1);
        ts_q.push_back(ts_of(fbase));
        send_ftr(fbase, 1'b1);
        exp_ok++;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || ts_q.size() != 0 || err_q.size() != 0) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 3000) begin
            n_chk++;
            $display("FAIL drain_timeout: got %0d/%0d/%0d pending expected 0/0/0",
                     exp_q.size(), ts_q.size(), err_q.size());
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_counters(input string tag);
        check({tag, "_frames_ok"},  frames_ok,  32'(exp_ok));
        check({tag, "_frames_err"}, frames_err, 32'(exp_err));
    endtask

    initial begin
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tlast  = 1'b0;
        m_if.tready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_m_tvalid",   m_if.tvalid, 1'b0);
        check("rst_s_tready",   s_if.tready, 1'b1);
        check("rst_m_ts",       m_ts, 72'h0);
        check("rst_frame_len",  m_frame_length, 16'h0);
        check("rst_errs",       {err_short, err_long, err_length, m_ts_valid}, 4'b0);
        check_counters("rst");
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // 64-beat frame, free-flowing output
        good_frame(64, 8'h00, 8'h01);
        drain();
        check("a_m_ts_literal", m_ts, 72'h090807060504030201);
        check("a_frame_len",    m_frame_length, 16'd64);
        check_counters("a");

        // Same frame with m_axis_tready toggling
        toggle_en = 1'b1;
        good_frame(64, 8'h00, 8'h01);
        drain();
        toggle_en = 1'b0;
        m_if.tready = 1'b1;
        check_counters("b");

        // Early tlast on payload beat 8 of 16, then a good frame
        send_hdr(16'h0010);
        err_q.push_back(E_SHORT);
        exp_err++;
        send_pay(9, 8'h80, 8, 8, 1'b1);
        drain();
        check_counters("c_short");
        good_frame(4, 8'hA0, 8'h11);
        drain();
        check_counters("c_good");

        // Zero length header, 20 dropped beats, then a good frame
        send_hdr(16'h0000);
        err_q.push_back(E_LENGTH);
        exp_err++;
        send_pay(20, 8'h10, 19, -1, 1'b0);
        good_frame(5, 8'h30, 8'h21);
        drain();
        check_counters("d");

        // Length just over the maximum, then a minimal 1-beat frame
        send_hdr(16'd1601);
        err_q.push_back(E_LENGTH);
        exp_err++;
        send_pay(3, 8'hE0, 2, -1, 1'b0);
        good_frame(1, 8'h77, 8'h41);
        drain();
        check("e_frame_len", m_frame_length, 16'd1);
        check_counters("e");

        // Footer without tlast on its final beat, extras dropped
        send_hdr(16'h0004);
        send_pay(4, 8'h55, -1, 3, 1'b1);
        err_q.push_back(E_LONG);
        exp_err++;
        send_ftr(8'h91, 1'b0);
        send_pay(3, 8'hF0, 2, -1, 1'b0);
        drain();
        check("f_m_ts_kept", m_ts, 72'h494847464544434241);
        check_counters("f");

        // tlast on a header beat
        err_q.push_back(E_SHORT);
        exp_err++;
        send_beat(8'h05, 1'b1);
        good_frame(2, 8'h50, 8'h61);
        drain();
        check_counters("g");

        // Reset during payload beat 10 of 64
        ignore_out = 1'b1;
        send_hdr(16'd64);
        send_pay(10, 8'h00, -1, -1, 1'b0);
        rstn = 1'b0;
        #1;
        check("h_tvalid_async", m_if.tvalid, 1'b0);
        exp_ok  = 0;
        exp_err = 0;
        check_counters("h_rst");
        check("h_m_ts", m_ts, 72'h0);
        check("h_s_tready", s_if.tready, 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        ignore_out = 1'b0;
        // Remainder of the interrupted frame parses as header 0x0B0A
        err_q.push_back(E_LENGTH);
        exp_err++;
        send_pay(54, 8'h0A, -1, -1, 1'b0);
        send_ftr(8'h01, 1'b1);
        good_frame(8, 8'hC0, 8'h71);
        drain();
        check("h_frame_len", m_frame_length, 16'd8);
        check_counters("h");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
